regfile_nport: RTL and testbench

Parametrised successor to the CPU-Core 8×16 register file. It adds configurable width and depth, independent read and write in the same cycle, and a synchronous clear. It also adds a multi-cycle sweep-clear sequencer with a busy flag and optional write-to-read bypass. It sits between the decode stage, which supplies the rs/rt addresses, and writeback, which supplies rd and its data. A tap port on the top register feeds the debug display.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_sweep_ctrl.sv | 54 +++++
 rtl/regfile_nport.sv | 93 +++++++++
 tb/tb_regfile_nport.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Sweep-clear sequencer: walks the index from 0 to DEPTH-1,
// zeroing one register per cycle, then returns to IDLE.
module regfile_sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_stb,
    output logic [ADDR_W-1:0] clear_idx
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'((2 ** ADDR_W) - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= SWEEP;
                        idx   <= '0;
                    end
                end
                SWEEP: begin
                    // Stop on the last register; the index never wraps.
                    if (idx == LAST) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign clear_busy = (state == SWEEP);
    assign clear_stb  = (state == SWEEP);
    assign clear_idx  = idx;

endmodule

// File: rtl/regfile_nport.sv
// Parametrised register file with registered read ports and sweep clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_nport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TAP_ADDR = (2 ** ADDR_W) - 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] tap_data,
    input  logic              clear_req,
    output logic              clear_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TAP_IDX = ADDR_W'(TAP_ADDR);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clear_stb;
    logic [ADDR_W-1:0] clear_idx;
    logic              wr_ok;
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;

    regfile_sweep_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_sweep (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .clear_stb (clear_stb),
        .clear_idx (clear_idx)
    );

    assign wr_ok = write && !clear_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (clear_stb) begin
                regs[clear_idx] <= '0;
            end
            if (wr_ok) begin
                regs[rd_addr] <= wr_data;
            end
        end
    end

    // Only accepted writes forward; sweep zeroing is never bypassed.
    always_comb begin
        rs_next = regs[rs_addr];
        rt_next = regs[rt_addr];
        if (BYPASS && wr_ok && (rd_addr == rs_addr)) begin
            rs_next = wr_data;
        end
        if (BYPASS && wr_ok && (rd_addr == rt_addr)) begin
            rt_next = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rs_data <= '0;
            rt_data <= '0;
        end else if (rd_en) begin
            rs_data <= rs_next;
            rt_data <= rt_next;
        end
    end

    assign tap_data = regs[TAP_IDX];

endmodule

// File: tb/tb_regfile_nport.sv
// Directed test of regfile_nport: default 8x16 build plus a 16x32 build.
module tb_regfile_nport;

    logic        clock = 1'b0;
    logic        reset;
    logic        write;
    logic [2:0]  rd_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] tap_data;
    logic        clear_req;
    logic        clear_busy;

    logic        b_write;
    logic [3:0]  b_rd_addr;
    logic [31:0] b_wr_data;
    logic        b_rd_en;
    logic [3:0]  b_rs_addr;
    logic [3:0]  b_rt_addr;
    logic [31:0] b_rs_data;
    logic [31:0] b_rt_data;
    logic [31:0] b_tap_data;
    logic        b_clear_req;
    logic        b_clear_busy;

    int checks   = 0;
    int failures = 0;
    int cnt;
    logic [15:0] same_exp;

    always #5 clock = ~clock;

    regfile_nport dut (
        .clock     (clock),
        .reset     (reset),
        .write     (write),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .tap_data  (tap_data),
        .clear_req (clear_req),
        .clear_busy(clear_busy)
    );

    regfile_nport #(
        .DATA_W(32),
        .ADDR_W(4)
    ) dut_b (
        .clock     (clock),
        .reset     (reset),
        .write     (b_write),
        .rd_addr   (b_rd_addr),
        .wr_data   (b_wr_data),
        .rd_en     (b_rd_en),
        .rs_addr   (b_rs_addr),
        .rt_addr   (b_rt_addr),
        .rs_data   (b_rs_data),
        .rt_data   (b_rt_data),
        .tap_data  (b_tap_data),
        .clear_req (b_clear_req),
        .clear_busy(b_clear_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        write   = 1'b1;
        rd_addr = 3'(a);
        wr_data = d;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input int s, input int t);
        rd_en   = 1'b1;
        rs_addr = 3'(s);
        rt_addr = 3'(t);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0; rd_addr = '0; wr_data = '0;
        rd_en = 1'b0; rs_addr = '0; rt_addr = '0;
        clear_req = 1'b0;
        b_write = 1'b0; b_rd_addr = '0; b_wr_data = '0;
        b_rd_en = 1'b0; b_rs_addr = '0; b_rt_addr = '0;
        b_clear_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rs", 32'(rs_data), 32'h0);
        chk("rst_rt", 32'(rt_data), 32'h0);
        chk("rst_busy", 32'(clear_busy), 32'h0);
        chk("rst_tap", 32'(tap_data), 32'h0);

        wr(3, 16'h1234);
        rd(3, 7);
        chk("rd_r3", 32'(rs_data), 32'h1234);
        chk("rd_r7", 32'(rt_data), 32'h0);

`ifdef REGFILE_BYPASS_EN
        same_exp = 16'hBEEF;
`else
        same_exp = 16'h0000;
`endif
        write = 1'b1; rd_addr = 3'd5; wr_data = 16'hBEEF;
        rd_en = 1'b1; rs_addr = 3'd5; rt_addr = 3'd5;
        tick();
        write = 1'b0; rd_en = 1'b0;
        chk("same_rs", 32'(rs_data), 32'(same_exp));
        chk("same_rt", 32'(rt_data), 32'(same_exp));
        rd(5, 5);
        chk("next_rs", 32'(rs_data), 32'hBEEF);

        wr(7, 16'hA5A5);
        chk("tap_a5", 32'(tap_data), 32'hA5A5);
        wr(2, 16'h2222);
        chk("hold_rs", 32'(rs_data), 32'hBEEF);
        chk("hold_rt", 32'(rt_data), 32'hBEEF);
        rd(2, 7);
        chk("rd_r2", 32'(rs_data), 32'h2222);

        for (int k = 0; k < 8; k++) wr(k, 16'(32'h1111 * k));
        rd(6, 1);
        chk("fill_r6", 32'(rs_data), 32'h6666);
        chk("fill_r1", 32'(rt_data), 32'h1111);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 40) begin
            cnt++;
            if (cnt == 3) begin
                write = 1'b1; rd_addr = 3'd1; wr_data = 16'hFFFF;
            end
            if (cnt == 4) clear_req = 1'b1;
            tick();
            write = 1'b0;
            clear_req = 1'b0;
        end
        chk("sweep_len", 32'(cnt), 32'd8);
        chk("sweep_tap", 32'(tap_data), 32'h0);
        for (int k = 0; k < 8; k++) begin
            rd(k, 7 - k);
            chk("swept_rs", 32'(rs_data), 32'h0);
            chk("swept_rt", 32'(rt_data), 32'h0);
        end
        wr(4, 16'h4444);
        rd(4, 4);
        chk("post_wr", 32'(rs_data), 32'h4444);

        for (int k = 0; k < 8; k++) wr(k, 16'hFFFF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(clear_busy), 32'h0);
        chk("abort_tap", 32'(tap_data), 32'h0);
        chk("abort_rs", 32'(rs_data), 32'h0);
        for (int k = 0; k < 8; k++) begin
            rd(k, k);
            chk("abort_reg", 32'(rs_data), 32'h0);
        end
        wr(5, 16'h5555);
        rd(5, 5);
        chk("abort_wr", 32'(rt_data), 32'h5555);

        b_write = 1'b1; b_rd_addr = 4'd15; b_wr_data = 32'hDEADBEEF;
        tick();
        b_write = 1'b0;
        chk("b_tap", b_tap_data, 32'hDEADBEEF);
        b_clear_req = 1'b1;
        tick();
        b_clear_req = 1'b0;
        cnt = 0;
        while (b_clear_busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("b_sweep_len", 32'(cnt), 32'd16);
        chk("b_tap_clr", b_tap_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
